// File: rtl/pwm_multichannel_peripheral.sv
// rtl/pwm_multichannel_peripheral.sv - NUM_CH-channel PWM with double-buffered duty, period and prescaler
module pwm_multichannel_peripheral #(
    parameter int NUM_CH  = 16,
    parameter int PRESC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [6:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_end
);
    localparam int NB = NUM_CH / 8;
    localparam logic [6:0] ADDR_PERIOD = 7'(2 * NB);
    localparam logic [6:0] ADDR_PRESC  = 7'(2 * NB + 1);
    localparam logic [6:0] ADDR_STATUS = 7'(2 * NB + 2);
    localparam int DUTY_BASE = 2 * NB + 3;

    logic [NUM_CH-1:0]  r_en_out;
    logic [NUM_CH-1:0]  r_en_pwm;
    logic [7:0]         r_period;
    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_duty [NUM_CH];

    logic [7:0]         r_period_act;
    logic [PRESC_W-1:0] r_presc_act;
    logic [7:0]         r_duty_act [NUM_CH];

    logic [PRESC_W-1:0] r_pcnt;
    logic [7:0]         r_cnt;
    logic [NUM_CH-1:0]  r_out;
    logic               r_period_end;
    logic               r_upd_pending;

    logic               w_tick;
    logic               w_boundary;
    logic               w_duty_hit;
    logic               w_upd_wr;
    logic [NUM_CH-1:0]  w_out_next;

    assign w_tick     = (r_pcnt == r_presc_act);
    assign w_boundary = w_tick && (r_cnt == r_period_act);

    always_comb begin
        w_duty_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_addr == 7'(DUTY_BASE + i)) w_duty_hit = 1'b1;
        end
    end

    assign w_upd_wr = wr_en && ((wr_addr == ADDR_PERIOD) || (wr_addr == ADDR_PRESC) || w_duty_hit);

    // Shadow registers: written directly by the bus, visible on readback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out <= '0;
            r_en_pwm <= '0;
            r_period <= '0;
            r_presc  <= '0;
            for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_addr == 7'(b))      r_en_out[b*8 +: 8] <= wr_data;
                if (wr_addr == 7'(NB + b)) r_en_pwm[b*8 +: 8] <= wr_data;
            end
            if (wr_addr == ADDR_PERIOD) r_period <= wr_data;
            if (wr_addr == ADDR_PRESC)  r_presc  <= wr_data[PRESC_W-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == 7'(DUTY_BASE + i)) r_duty[i] <= wr_data;
            end
        end
    end

    always_comb begin
        w_out_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_out_next[i] = r_en_out[i] && (!r_en_pwm[i] || (r_cnt < r_duty_act[i]));
        end
    end

    // Active copies load from the pre-write shadow, so a colliding write waits a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_act  <= '0;
            r_presc_act   <= '0;
            for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= '0;
            r_pcnt        <= '0;
            r_cnt         <= '0;
            r_out         <= '0;
            r_period_end  <= 1'b0;
            r_upd_pending <= 1'b0;
        end else begin
            r_pcnt       <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
            if (w_tick) r_cnt <= (r_cnt == r_period_act) ? 8'd0 : r_cnt + 8'd1;
            r_out        <= w_out_next;
            r_period_end <= w_boundary;
            if (w_boundary) begin
                r_period_act <= r_period;
                r_presc_act  <= r_presc;
                for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty[i];
            end
            if (w_upd_wr)        r_upd_pending <= 1'b1;
            else if (w_boundary) r_upd_pending <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (rd_addr == 7'(b))      rd_data = r_en_out[b*8 +: 8];
            if (rd_addr == 7'(NB + b)) rd_data = r_en_pwm[b*8 +: 8];
        end
        if (rd_addr == ADDR_PERIOD) rd_data = r_period;
        if (rd_addr == ADDR_PRESC)  rd_data = 8'(r_presc);
        if (rd_addr == ADDR_STATUS) rd_data = {7'd0, r_upd_pending};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == 7'(DUTY_BASE + i)) rd_data = r_duty[i];
        end
    end

    assign out        = r_out;
    assign period_end = r_period_end;

endmodule

// File: tb/tb_pwm_multichannel_peripheral.sv
// tb/tb_pwm_multichannel_peripheral.sv - scoreboard bench measuring per-period high time and length
`timescale 1ns/100ps
module tb_pwm_multichannel_peripheral;
    localparam int NUM_CH  = 16;
    localparam int PRESC_W = 4;
    localparam logic [6:0] A_EN_OUT0 = 7'd0;
    localparam logic [6:0] A_EN_OUT1 = 7'd1;
    localparam logic [6:0] A_EN_PWM0 = 7'd2;
    localparam logic [6:0] A_PERIOD  = 7'd4;
    localparam logic [6:0] A_PRESC   = 7'd5;
    localparam logic [6:0] A_STATUS  = 7'd6;
    localparam logic [6:0] A_DUTY0   = 7'd7;
    localparam logic [6:0] A_DUTY3   = 7'd10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [6:0]        wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic [6:0]        rd_addr = '0;
    logic [7:0]        rd_data;
    logic [NUM_CH-1:0] out;
    logic              period_end;

    always #5 clk = ~clk;

    pwm_multichannel_peripheral #(.NUM_CH(NUM_CH), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .out(out), .period_end(period_end)
    );

    typedef struct { int hi; int len; int other; } win_t;
    win_t exp_q[$];
    win_t obs_q[$];
    int checks = 0;
    int failures = 0;

    bit mon_on = 1'b0;
    bit mon_synced = 1'b0;
    int mon_ch = 3;
    int mon_hi, mon_len, mon_other;

    // One window spans from the cycle after a period_end up to and including the next one
    always @(negedge clk) begin
        if (!rst_n || !mon_on) begin
            mon_synced = 1'b0;
        end else begin
            if (mon_synced) begin
                mon_hi += int'(out[mon_ch]);
                mon_len++;
                if ((out & ~(16'd1 << mon_ch)) != '0) mon_other++;
            end
            if (period_end) begin
                if (mon_synced) obs_q.push_back('{mon_hi, mon_len, mon_other});
                mon_synced = 1'b1;
                mon_hi = 0;
                mon_len = 0;
                mon_other = 0;
            end
        end
    end

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic start_mon(input int ch);
        int t = 0;
        mon_ch = ch;
        obs_q.delete();
        mon_on = 1'b1;
        while (!mon_synced && t < 3000) begin @(negedge clk); #1; t++; end
    endtask

    task automatic stop_mon();
        mon_on = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic collect(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 3000) begin @(negedge clk); #1; t++; end
        checks++;
        if (obs_q.size() < n) begin
            failures++;
            $display("FAIL collect_timeout windows=%0d required=%0d", obs_q.size(), n);
        end
    endtask

    task automatic wait_applied();
        logic [7:0] s;
        int t = 0;
        rd(A_STATUS, s);
        while (s[0] && t < 3000) begin @(negedge clk); rd(A_STATUS, s); t++; end
        checks++;
        if (s[0]) begin failures++; $display("FAIL upd_pending_stuck status=%0h required=0", s); end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        #1;
        checks++;
        if (out !== '0 || period_end !== 1'b0) begin
            failures++; $display("FAIL reset_initial out=%h pe=%b required 0/0", out, period_end);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr(A_EN_OUT0, 8'hFF);
        wr(A_EN_OUT1, 8'hFF);
        wr(A_PERIOD, 8'd99);
        repeat (3) @(negedge clk);
        wr(A_DUTY0, 8'd5);
        wr(A_PRESC, 8'd2);
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (out !== 16'hFFFF) begin failures++; $display("FAIL pre_reset_out out=%h required=ffff", out); end
        rd(A_STATUS, d);
        checks++;
        if (d !== 8'h01) begin failures++; $display("FAIL pre_reset_status status=%h required=01", d); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== '0 || period_end !== 1'b0) begin
            failures++; $display("FAIL reset_async out=%h pe=%b required 0/0", out, period_end);
        end
        for (int a = 0; a < 128; a++) begin
            rd(7'(a), d);
            checks++;
            if (d !== 8'h00) begin failures++; $display("FAIL reset_rd addr=%0d rd=%h required=00", a, d); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_duty();
        win_t e, o;
        wr(A_EN_OUT0, 8'h08);
        wr(A_EN_PWM0, 8'h08);
        wr(A_DUTY3, 8'd25);
        wr(A_PRESC, 8'd0);
        wr(A_PERIOD, 8'd99);
        wait_applied();
        start_mon(3);
        exp_q.push_back('{25, 100, 0});
        exp_q.push_back('{25, 100, 0});
        collect(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '{-1, -1, -1};
            checks++;
            if (o.hi !== e.hi || o.len !== e.len || o.other !== e.other) begin
                failures++;
                $display("FAIL duty_window hi=%0d len=%0d other=%0d required hi=%0d len=%0d other=%0d",
                         o.hi, o.len, o.other, e.hi, e.len, e.other);
            end
        end
        stop_mon();
    endtask

    task automatic test_double_buffer();
        win_t e, o;
        logic [7:0] d;
        start_mon(3);
        repeat (30) @(negedge clk);
        exp_q.push_back('{25, 100, 0});
        exp_q.push_back('{75, 100, 0});
        wr(A_DUTY3, 8'd75);
        rd(A_STATUS, d);
        checks++;
        if (d !== 8'h01) begin failures++; $display("FAIL dbuf_pending status=%h required=01", d); end
        rd(A_DUTY3, d);
        checks++;
        if (d !== 8'd75) begin failures++; $display("FAIL dbuf_shadow_rd rd=%0d required=75", d); end
        collect(1);
        rd(A_STATUS, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL dbuf_cleared status=%h required=00", d); end
        collect(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '{-1, -1, -1};
            checks++;
            if (o.hi !== e.hi || o.len !== e.len || o.other !== e.other) begin
                failures++;
                $display("FAIL dbuf_window hi=%0d len=%0d other=%0d required hi=%0d len=%0d other=%0d",
                         o.hi, o.len, o.other, e.hi, e.len, e.other);
            end
        end
        stop_mon();
    endtask

    task automatic test_extremes();
        win_t e, o;
        logic [7:0] duty_t [5] = '{8'd0, 8'd100, 8'd255, 8'd0, 8'd255};
        logic [7:0] eno_t  [5] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
        logic [7:0] enp_t  [5] = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h08};
        int         hi_t   [5] = '{0, 100, 100, 100, 0};
        for (int k = 0; k < 5; k++) begin
            wr(A_EN_OUT0, eno_t[k]);
            wr(A_EN_PWM0, enp_t[k]);
            wr(A_DUTY3, duty_t[k]);
            wait_applied();
            start_mon(3);
            exp_q.push_back('{hi_t[k], 100, 0});
            collect(1);
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '{-1, -1, -1};
            checks++;
            if (o.hi !== e.hi || o.len !== e.len || o.other !== e.other) begin
                failures++;
                $display("FAIL extreme_%0d hi=%0d len=%0d other=%0d required hi=%0d len=%0d other=%0d",
                         k, o.hi, o.len, o.other, e.hi, e.len, e.other);
            end
            stop_mon();
        end
        wr(A_EN_OUT0, 8'h08);
        #1;
        checks++;
        if (out[3] !== 1'b0) begin failures++; $display("FAIL en_latency_1st out3=%b required=0", out[3]); end
        @(negedge clk);
        #1;
        checks++;
        if (out[3] !== 1'b1) begin failures++; $display("FAIL en_latency_2nd out3=%b required=1", out[3]); end
    endtask

    task automatic test_prescaler();
        win_t e, o;
        wr(A_EN_OUT0, 8'h08);
        wr(A_EN_PWM0, 8'h08);
        wr(A_DUTY3, 8'd5);
        wr(A_PRESC, 8'd3);
        wr(A_PERIOD, 8'd9);
        wait_applied();
        start_mon(3);
        exp_q.push_back('{20, 40, 0});
        exp_q.push_back('{20, 40, 0});
        exp_q.push_back('{5, 10, 0});
        repeat (49) @(negedge clk);
        wr(A_PRESC, 8'd0);
        collect(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '{-1, -1, -1};
            checks++;
            if (o.hi !== e.hi || o.len !== e.len || o.other !== e.other) begin
                failures++;
                $display("FAIL presc_window hi=%0d len=%0d other=%0d required hi=%0d len=%0d other=%0d",
                         o.hi, o.len, o.other, e.hi, e.len, e.other);
            end
        end
        stop_mon();
    endtask

    task automatic test_collision();
        win_t e, o;
        logic [7:0] d;
        int t = 0;
        wr(A_EN_OUT0, 8'h01);
        wr(A_EN_PWM0, 8'h01);
        wr(A_DUTY0, 8'd2);
        wait_applied();
        start_mon(0);
        @(negedge clk); #1;
        while (!period_end && t < 100) begin @(negedge clk); #1; t++; end
        exp_q.push_back('{2, 10, 0});
        exp_q.push_back('{2, 10, 0});
        exp_q.push_back('{2, 10, 0});
        exp_q.push_back('{7, 10, 0});
        repeat (8) @(negedge clk);
        wr(A_DUTY0, 8'd7);
        #1;
        checks++;
        if (period_end !== 1'b1) begin failures++; $display("FAIL coll_align pe=%b required=1", period_end); end
        rd(A_STATUS, d);
        checks++;
        if (d !== 8'h01) begin failures++; $display("FAIL coll_pending_at status=%h required=01", d); end
        repeat (5) @(negedge clk);
        rd(A_STATUS, d);
        checks++;
        if (d !== 8'h01) begin failures++; $display("FAIL coll_pending_mid status=%h required=01", d); end
        collect(3);
        rd(A_STATUS, d);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL coll_pending_end status=%h required=00", d); end
        collect(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '{-1, -1, -1};
            checks++;
            if (o.hi !== e.hi || o.len !== e.len || o.other !== e.other) begin
                failures++;
                $display("FAIL coll_window hi=%0d len=%0d other=%0d required hi=%0d len=%0d other=%0d",
                         o.hi, o.len, o.other, e.hi, e.len, e.other);
            end
        end
        stop_mon();
    endtask

    initial begin
        test_reset();
        test_duty();
        test_double_buffer();
        test_extremes();
        test_prescaler();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog_timeout time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
